// File: rtl/mtrap_unit.sv
// mtrap_unit -- machine-mode trap unit for the RV32 core.
//
// Purpose:
//   Owns mstatus (MIE/MPIE), mie, mip, mtvec, mepc, mcause and mtval.
//   Synchronises the MEI/MSI/MTI inputs and NUM_LIRQ local interrupts.
//   Arbitrates exceptions and interrupts at a fixed priority.
//   Hands the chosen trap to fetch through a trap_req/trap_ack handshake.
//
// Ports:
//   cpu_clk, cpu_rst              clock, synchronous active-high reset
//   kplic_int/timer_int/soft_int  MEI (11), MTI (7), MSI (3), all level
//   lirq[NUM_LIRQ]                local interrupts, causes 16+i
//   exc_valid/exc_code/exc_pc/exc_tval  exception from the pipeline
//   int_pc, irq_ok                resume pc and interruptible boundary
//   mret                          mret retiring
//   trap_req/trap_ack/trap_vector trap handoff to fetch (registered)
//   mepc_out                      mret target
//   csr_wr_en/csr_addr/csr_wr_data/csr_rd_data/csr_hit  CSR access
module mtrap_unit #(
  parameter int                  XLEN        = 32,
  parameter int                  NUM_LIRQ    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [NUM_LIRQ-1:0] LIRQ_EDGE   = '0,
  parameter logic [XLEN-1:0]     RESET_VEC   = '0
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic                kplic_int,
  input  logic                timer_int,
  input  logic                soft_int,
  input  logic [NUM_LIRQ-1:0] lirq,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code,
  input  logic [XLEN-1:0]     exc_pc,
  input  logic [XLEN-1:0]     exc_tval,
  input  logic [XLEN-1:0]     int_pc,
  input  logic                irq_ok,
  input  logic                mret,
  input  logic                trap_ack,
  output logic                trap_req,
  output logic [XLEN-1:0]     trap_vector,
  output logic [XLEN-1:0]     mepc_out,
  input  logic                csr_wr_en,
  input  logic [11:0]         csr_addr,
  input  logic [XLEN-1:0]     csr_wr_data,
  output logic [XLEN-1:0]     csr_rd_data,
  output logic                csr_hit
);

  localparam int NUM_SRC = NUM_LIRQ + 3;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  function automatic logic [XLEN-1:0] mie_mask_f();
    logic [XLEN-1:0] m;
    m     = '0;
    m[3]  = 1'b1;
    m[7]  = 1'b1;
    m[11] = 1'b1;
    for (int i = 0; i < NUM_LIRQ; i++) m[16+i] = 1'b1;
    return m;
  endfunction

  localparam logic [XLEN-1:0] MIE_MASK = mie_mask_f();

  typedef enum logic [0:0] {RUN, REQ} state_t;

  // ---------------------------------------------------------------
  // Interrupt synchronisers. Lane order: MSI, MTI, MEI, lirq[0..N-1].
  // ---------------------------------------------------------------
  logic [NUM_SRC-1:0] irq_raw;
  logic [NUM_SRC-1:0] sync_reg [SYNC_STAGES];
  logic [NUM_SRC-1:0] irq_sync;

  assign irq_raw  = {lirq, kplic_int, timer_int, soft_int};
  assign irq_sync = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
    end else begin
      sync_reg[0] <= irq_raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
    end
  end

  // ---------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------
  state_t          state_reg;
  logic            trap_req_reg;
  logic [XLEN-1:0] trap_vector_reg;
  logic            mstatus_mie_reg;
  logic            mstatus_mpie_reg;
  logic [XLEN-1:0] mie_reg;
  logic [XLEN-1:0] mtvec_reg;
  logic [XLEN-1:0] mepc_reg;
  logic [XLEN-1:0] mcause_reg;
  logic [XLEN-1:0] mtval_reg;

  // CSR write strobes
  logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mtval, wr_mip;
  assign wr_mstatus = csr_wr_en && (csr_addr == ADDR_MSTATUS);
  assign wr_mie     = csr_wr_en && (csr_addr == ADDR_MIE);
  assign wr_mtvec   = csr_wr_en && (csr_addr == ADDR_MTVEC);
  assign wr_mepc    = csr_wr_en && (csr_addr == ADDR_MEPC);
  assign wr_mcause  = csr_wr_en && (csr_addr == ADDR_MCAUSE);
  assign wr_mtval   = csr_wr_en && (csr_addr == ADDR_MTVAL);
  assign wr_mip     = csr_wr_en && (csr_addr == ADDR_MIP);

  // ---------------------------------------------------------------
  // Edge-mode pending bits for the local interrupts
  // ---------------------------------------------------------------
  logic [NUM_LIRQ-1:0] sync_prev_reg;
  logic [NUM_LIRQ-1:0] edge_pend_reg;
  logic [NUM_LIRQ-1:0] edge_pend_next;
  logic [NUM_LIRQ-1:0] lirq_rise;
  logic [NUM_LIRQ-1:0] lirq_clr;
  logic [NUM_LIRQ-1:0] lirq_taken;

  // Arbitration results (computed below)
  logic            int_valid;
  logic [4:0]      int_code;
  logic            take_exc;
  logic            take_int;
  logic            capture;

  assign lirq_rise = irq_sync[NUM_SRC-1:3] & ~sync_prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LIRQ; gi++) begin : g_lirq
      assign lirq_taken[gi] = capture && take_int && (int_code == 5'(16 + gi));
      // A mip write clears only where the written bit is 0.
      assign lirq_clr[gi]   = (wr_mip && !csr_wr_data[16+gi]) || lirq_taken[gi];
    end
  endgenerate

  // Set beats clear; level lanes never hold a pending bit.
  assign edge_pend_next = LIRQ_EDGE & (lirq_rise | (edge_pend_reg & ~lirq_clr));

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      sync_prev_reg <= '0;
      edge_pend_reg <= '0;
    end else begin
      sync_prev_reg <= irq_sync[NUM_SRC-1:3];
      edge_pend_reg <= edge_pend_next;
    end
  end

  // ---------------------------------------------------------------
  // mip view and fixed-priority arbitration
  // ---------------------------------------------------------------
  logic [XLEN-1:0] mip_val;
  logic [XLEN-1:0] irq_elig;

  always_comb begin
    mip_val     = '0;
    mip_val[3]  = irq_sync[0];
    mip_val[7]  = irq_sync[1];
    mip_val[11] = irq_sync[2];
    for (int i = 0; i < NUM_LIRQ; i++) begin
      mip_val[16+i] = LIRQ_EDGE[i] ? edge_pend_reg[i] : irq_sync[3+i];
    end
  end

  assign irq_elig = mip_val & mie_reg & {XLEN{mstatus_mie_reg}};

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    int_valid = 1'b0;
    int_code  = 5'd0;
    for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
      if (irq_elig[16+i]) begin
        int_valid = 1'b1;
        int_code  = 5'(16 + i);
      end
    end
    if (irq_elig[7])  begin int_valid = 1'b1; int_code = 5'd7;  end
    if (irq_elig[3])  begin int_valid = 1'b1; int_code = 5'd3;  end
    if (irq_elig[11]) begin int_valid = 1'b1; int_code = 5'd11; end
  end

  assign take_exc = exc_valid;
  assign take_int = !exc_valid && int_valid && irq_ok;
  assign capture  = (state_reg == RUN) && (take_exc || take_int);

  // ---------------------------------------------------------------
  // Capture values
  // ---------------------------------------------------------------
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] vec_next;
  logic [XLEN-1:0] cause_next;
  logic [XLEN-1:0] epc_next;

  assign vec_base = {mtvec_reg[XLEN-1:2], 2'b00};
  // Only mode 01 vectors; modes 10/11 fall back to direct.
  assign vec_next = (take_int && (mtvec_reg[1:0] == 2'b01))
                  ? vec_base + (XLEN'(int_code) << 2)
                  : vec_base;
  assign epc_next = take_exc ? exc_pc : int_pc;

  always_comb begin
    cause_next         = '0;
    cause_next[4:0]    = take_exc ? exc_code : int_code;
    cause_next[XLEN-1] = !take_exc;
  end

  // ---------------------------------------------------------------
  // FSM and CSR state
  // ---------------------------------------------------------------
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_reg        <= RUN;
      trap_req_reg     <= 1'b0;
      trap_vector_reg  <= '0;
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= '0;
      mtvec_reg        <= RESET_VEC;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      mtval_reg        <= '0;
    end else begin
      // mie and mtvec writes are honoured even in a capture cycle.
      if (wr_mie)   mie_reg   <= csr_wr_data & MIE_MASK;
      if (wr_mtvec) mtvec_reg <= csr_wr_data;

      // Trap-state CSRs lose to a simultaneous capture.
      if (!capture) begin
        if (wr_mstatus) begin
          mstatus_mie_reg  <= csr_wr_data[3];
          mstatus_mpie_reg <= csr_wr_data[7];
        end
        if (wr_mepc)   mepc_reg   <= {csr_wr_data[XLEN-1:2], 2'b00};
        if (wr_mcause) mcause_reg <= csr_wr_data;
        if (wr_mtval)  mtval_reg  <= csr_wr_data;
      end

      case (state_reg)
        RUN: begin
          if (capture) begin
            state_reg        <= REQ;
            trap_req_reg     <= 1'b1;
            trap_vector_reg  <= vec_next;
            mepc_reg         <= {epc_next[XLEN-1:2], 2'b00};
            mcause_reg       <= cause_next;
            mtval_reg        <= take_exc ? exc_tval : '0;
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
          end else if (mret) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
          end
        end
        REQ: begin
          if (trap_ack) begin
            state_reg    <= RUN;
            trap_req_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= RUN;
          trap_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign trap_req    = trap_req_reg;
  assign trap_vector = trap_vector_reg;
  assign mepc_out    = mepc_reg;

  // ---------------------------------------------------------------
  // CSR read mux
  // ---------------------------------------------------------------
  always_comb begin
    csr_rd_data = '0;
    csr_hit     = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS: begin
        csr_rd_data[3]     = mstatus_mie_reg;
        csr_rd_data[7]     = mstatus_mpie_reg;
        csr_rd_data[12:11] = 2'b11;
      end
      ADDR_MIE:    csr_rd_data = mie_reg;
      ADDR_MTVEC:  csr_rd_data = mtvec_reg;
      ADDR_MEPC:   csr_rd_data = mepc_reg;
      ADDR_MCAUSE: csr_rd_data = mcause_reg;
      ADDR_MTVAL:  csr_rd_data = mtval_reg;
      ADDR_MIP:    csr_rd_data = mip_val;
      default:     csr_hit     = 1'b0;
    endcase
  end

  // Low pc bits are always forced to zero in mepc.
  logic unused_bits;
  assign unused_bits = ^{exc_pc[1:0], int_pc[1:0]};

endmodule

// File: tb/tb_mtrap_unit.sv
// tb_mtrap_unit -- directed bench for mtrap_unit (RESET_VEC=0x100, lirq[1] edge mode).
`timescale 1ns/1ps
module tb_mtrap_unit;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        kplic_int, timer_int, soft_int;
  logic [3:0]  lirq;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_tval, int_pc;
  logic        irq_ok, mret, trap_ack;
  logic        trap_req;
  logic [31:0] trap_vector, mepc_out;
  logic        csr_wr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wr_data, csr_rd_data;
  logic        csr_hit;

  int n_vec = 0;
  int n_err = 0;

  mtrap_unit #(
    .XLEN(32), .NUM_LIRQ(4), .SYNC_STAGES(2),
    .LIRQ_EDGE(4'b0010), .RESET_VEC(32'h0000_0100)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .kplic_int(kplic_int), .timer_int(timer_int), .soft_int(soft_int),
    .lirq(lirq),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .int_pc(int_pc), .irq_ok(irq_ok), .mret(mret), .trap_ack(trap_ack),
    .trap_req(trap_req), .trap_vector(trap_vector), .mepc_out(mepc_out),
    .csr_wr_en(csr_wr_en), .csr_addr(csr_addr), .csr_wr_data(csr_wr_data),
    .csr_rd_data(csr_rd_data), .csr_hit(csr_hit)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200us");
    $fatal(1);
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_wr_en   = 1'b1;
    csr_addr    = a;
    csr_wr_data = d;
    tick();
    csr_wr_en   = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = csr_rd_data;
  endtask

  task automatic ack();
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    cpu_rst = 1'b1;
    tick(); tick();
    cpu_rst = 1'b0;
    $display("txn reset");
    n_vec++; if (trap_req !== 1'b0) begin n_err++; $display("FAIL reset_trap_req: got %0b want 0", trap_req); end
    n_vec++; if (mepc_out !== 32'h0) begin n_err++; $display("FAIL reset_mepc: got %h want 0", mepc_out); end
    csr_rd(12'h305, d);
    n_vec++; if (d !== 32'h100) begin n_err++; $display("FAIL reset_mtvec: got %h want 00000100", d); end
    csr_rd(12'h342, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mcause: got %h want 0", d); end
    csr_rd(12'h300, d);
    n_vec++; if (d !== 32'h1800) begin n_err++; $display("FAIL reset_mstatus: got %h want 00001800", d); end
    n_vec++; if (csr_hit !== 1'b1) begin n_err++; $display("FAIL reset_hit_mstatus: got %0b want 1", csr_hit); end
    csr_rd(12'h304, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_mie: got %h want 0", d); end
    tick();
    csr_rd(12'h123, d);
    n_vec++; if (d !== 32'h0 || csr_hit !== 1'b0) begin n_err++; $display("FAIL unowned_csr: got data %h hit %0b want 0/0", d, csr_hit); end
  endtask

  task automatic test_mei_vectored();
    logic [31:0] d;
    logic exp;
    csr_wr(12'h305, 32'h1001);
    csr_wr(12'h304, 32'h800);
    csr_wr(12'h300, 32'h8);
    int_pc = 32'h2000_0040; irq_ok = 1'b1; kplic_int = 1'b1;
    $display("txn mei_vectored");
    for (int c = 1; c <= 3; c++) begin
      tick();
      exp = (c == 3);
      n_vec++; if (trap_req !== exp) begin n_err++; $display("FAIL mei_latency_c%0d: got %0b want %0b", c, trap_req, exp); end
    end
    irq_ok = 1'b0;
    n_vec++; if (trap_vector !== 32'h102C) begin n_err++; $display("FAIL mei_vector: got %h want 0000102c", trap_vector); end
    n_vec++; if (mepc_out !== 32'h2000_0040) begin n_err++; $display("FAIL mei_mepc: got %h want 20000040", mepc_out); end
    csr_rd(12'h342, d);
    n_vec++; if (d !== 32'h8000_000B) begin n_err++; $display("FAIL mei_mcause: got %h want 8000000b", d); end
    csr_rd(12'h300, d);
    n_vec++; if (d !== 32'h1880) begin n_err++; $display("FAIL mei_mstatus: got %h want 00001880", d); end
    csr_rd(12'h344, d);
    n_vec++; if (d !== 32'h800) begin n_err++; $display("FAIL mei_mip: got %h want 00000800", d); end
    ack();
    n_vec++; if (trap_req !== 1'b0) begin n_err++; $display("FAIL mei_one_cycle_req: got %0b want 0", trap_req); end
    kplic_int = 1'b0;
    csr_wr(12'h304, 32'h0);
    tick(); tick(); tick();
  endtask

  task automatic test_exc_priority();
    logic [31:0] d;
    csr_wr(12'h304, 32'h80);
    csr_wr(12'h300, 32'h8);
    timer_int = 1'b1;
    tick(); tick(); tick();
    $display("txn exc_vs_mti");
    csr_rd(12'h344, d);
    n_vec++; if (d !== 32'h80) begin n_err++; $display("FAIL mti_pending: got %h want 00000080", d); end
    exc_valid = 1'b1; exc_code = 5'd2; exc_pc = 32'h3000_0010; exc_tval = 32'hDEAD_BEEF;
    irq_ok = 1'b1; int_pc = 32'h3000_0020;
    tick();
    exc_valid = 1'b0; irq_ok = 1'b0;
    n_vec++; if (trap_req !== 1'b1) begin n_err++; $display("FAIL exc_req: got %0b want 1", trap_req); end
    n_vec++; if (trap_vector !== 32'h1000) begin n_err++; $display("FAIL exc_vector: got %h want 00001000", trap_vector); end
    n_vec++; if (mepc_out !== 32'h3000_0010) begin n_err++; $display("FAIL exc_mepc: got %h want 30000010", mepc_out); end
    csr_rd(12'h342, d);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL exc_mcause: got %h want 00000002", d); end
    csr_rd(12'h343, d);
    n_vec++; if (d !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL exc_mtval: got %h want deadbeef", d); end
    csr_rd(12'h300, d);
    n_vec++; if (d !== 32'h1880) begin n_err++; $display("FAIL exc_mstatus: got %h want 00001880", d); end
    csr_rd(12'h344, d);
    n_vec++; if (d !== 32'h80) begin n_err++; $display("FAIL mti_still_pending: got %h want 00000080", d); end
    ack();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    $display("txn mret");
    csr_rd(12'h300, d);
    n_vec++; if (d !== 32'h1888) begin n_err++; $display("FAIL mret_mstatus: got %h want 00001888", d); end
    irq_ok = 1'b1;
    tick();
    irq_ok = 1'b0;
    $display("txn mti_after_mret");
    n_vec++; if (trap_req !== 1'b1) begin n_err++; $display("FAIL mti_req: got %0b want 1", trap_req); end
    n_vec++; if (trap_vector !== 32'h101C) begin n_err++; $display("FAIL mti_vector: got %h want 0000101c", trap_vector); end
    n_vec++; if (mepc_out !== 32'h3000_0020) begin n_err++; $display("FAIL mti_mepc: got %h want 30000020", mepc_out); end
    csr_rd(12'h342, d);
    n_vec++; if (d !== 32'h8000_0007) begin n_err++; $display("FAIL mti_mcause: got %h want 80000007", d); end
    ack();
    timer_int = 1'b0;
    csr_wr(12'h304, 32'h0);
    tick(); tick(); tick();
  endtask

  task automatic test_edge_lirq();
    logic [31:0] d;
    lirq = 4'b0010;
    tick();
    lirq = 4'b0000;
    tick(); tick(); tick(); tick();
    $display("txn lirq1_pulse");
    csr_rd(12'h344, d);
    n_vec++; if (d !== 32'h2_0000) begin n_err++; $display("FAIL edge_latch: got %h want 00020000", d); end
    csr_wr(12'h344, 32'hFFFF_FFFF);
    csr_rd(12'h344, d);
    n_vec++; if (d !== 32'h2_0000) begin n_err++; $display("FAIL mip_write_one: got %h want 00020000", d); end
    csr_wr(12'h344, 32'h0);
    csr_rd(12'h344, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL mip_clear: got %h want 0", d); end
    lirq = 4'b0010;
    tick();
    lirq = 4'b0000;
    tick();
    csr_wr(12'h344, 32'h0);
    $display("txn lirq1_set_vs_clear");
    csr_rd(12'h344, d);
    n_vec++; if (d !== 32'h2_0000) begin n_err++; $display("FAIL set_beats_clear: got %h want 00020000", d); end
    csr_wr(12'h304, 32'h2_0000);
    irq_ok = 1'b1; int_pc = 32'h0000_0040;
    csr_wr(12'h300, 32'h8);
    tick();
    irq_ok = 1'b0;
    $display("txn lirq1_trap");
    n_vec++; if (trap_req !== 1'b1) begin n_err++; $display("FAIL lirq_req: got %0b want 1", trap_req); end
    n_vec++; if (trap_vector !== 32'h1044) begin n_err++; $display("FAIL lirq_vector: got %h want 00001044", trap_vector); end
    csr_rd(12'h342, d);
    n_vec++; if (d !== 32'h8000_0011) begin n_err++; $display("FAIL lirq_mcause: got %h want 80000011", d); end
    csr_rd(12'h344, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL lirq_taken_clear: got %h want 0", d); end
    ack();
    csr_wr(12'h304, 32'h0);
  endtask

  task automatic test_hold_ack();
    logic [31:0] d;
    csr_wr(12'h305, 32'h2000);
    exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h4000_0000; exc_tval = 32'h44;
    tick();
    exc_valid = 1'b0;
    $display("txn hold_ack");
    n_vec++; if (trap_req !== 1'b1 || trap_vector !== 32'h2000) begin n_err++; $display("FAIL hold_start: got req %0b vec %h want 1/00002000", trap_req, trap_vector); end
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        exc_valid = 1'b1; exc_code = 5'd7; exc_pc = 32'h5000_0004; exc_tval = 32'h77;
      end
      tick();
      exc_valid = 1'b0;
      n_vec++; if (trap_req !== 1'b1) begin n_err++; $display("FAIL hold_req_c%0d: got %0b want 1", c, trap_req); end
      n_vec++; if (trap_vector !== 32'h2000) begin n_err++; $display("FAIL hold_vec_c%0d: got %h want 00002000", c, trap_vector); end
    end
    csr_rd(12'h342, d);
    n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL hold_mcause: got %h want 00000005", d); end
    csr_rd(12'h343, d);
    n_vec++; if (d !== 32'h44) begin n_err++; $display("FAIL hold_mtval: got %h want 00000044", d); end
    n_vec++; if (mepc_out !== 32'h4000_0000) begin n_err++; $display("FAIL hold_mepc: got %h want 40000000", mepc_out); end
    ack();
    n_vec++; if (trap_req !== 1'b0) begin n_err++; $display("FAIL hold_release: got %0b want 0", trap_req); end
    tick();
    n_vec++; if (trap_req !== 1'b0) begin n_err++; $display("FAIL hold_no_retrap: got %0b want 0", trap_req); end
  endtask

  task automatic test_mret_exc();
    logic [31:0] d;
    csr_wr(12'h300, 32'h80);
    mret = 1'b1;
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'h5000_0000; exc_tval = 32'h55;
    csr_wr(12'h341, 32'h1234_5678);
    mret = 1'b0; exc_valid = 1'b0;
    $display("txn mret_vs_exc");
    n_vec++; if (trap_req !== 1'b1) begin n_err++; $display("FAIL mx_req: got %0b want 1", trap_req); end
    n_vec++; if (mepc_out !== 32'h5000_0000) begin n_err++; $display("FAIL mx_mepc_write_dropped: got %h want 50000000", mepc_out); end
    csr_rd(12'h300, d);
    n_vec++; if (d !== 32'h1800) begin n_err++; $display("FAIL mx_mstatus: got %h want 00001800", d); end
    csr_rd(12'h342, d);
    n_vec++; if (d !== 32'h4) begin n_err++; $display("FAIL mx_mcause: got %h want 00000004", d); end
    csr_rd(12'h343, d);
    n_vec++; if (d !== 32'h55) begin n_err++; $display("FAIL mx_mtval: got %h want 00000055", d); end
    ack();
    csr_wr(12'h341, 32'h1234_5677);
    $display("txn mepc_write");
    csr_rd(12'h341, d);
    n_vec++; if (d !== 32'h1234_5674) begin n_err++; $display("FAIL mepc_low_bits: got %h want 12345674", d); end
    n_vec++; if (mepc_out !== 32'h1234_5674) begin n_err++; $display("FAIL mepc_out: got %h want 12345674", mepc_out); end
  endtask

  task automatic test_csr_misc();
    logic [31:0] d;
    csr_wr(12'h304, 32'hFFFF_FFFF);
    $display("txn mie_mask");
    csr_rd(12'h304, d);
    n_vec++; if (d !== 32'h000F_0888) begin n_err++; $display("FAIL mie_mask: got %h want 000f0888", d); end
    csr_wr(12'h304, 32'h8);
    csr_wr(12'h305, 32'h3002);
    soft_int = 1'b1;
    tick(); tick(); tick();
    csr_wr(12'h300, 32'h8);
    irq_ok = 1'b1;
    csr_wr(12'h305, 32'h4000);
    irq_ok = 1'b0;
    $display("txn msi_mode2");
    n_vec++; if (trap_req !== 1'b1) begin n_err++; $display("FAIL msi_req: got %0b want 1", trap_req); end
    n_vec++; if (trap_vector !== 32'h3000) begin n_err++; $display("FAIL msi_mode2_direct: got %h want 00003000", trap_vector); end
    csr_rd(12'h342, d);
    n_vec++; if (d !== 32'h8000_0003) begin n_err++; $display("FAIL msi_mcause: got %h want 80000003", d); end
    csr_rd(12'h305, d);
    n_vec++; if (d !== 32'h4000) begin n_err++; $display("FAIL mtvec_write_in_capture: got %h want 00004000", d); end
    ack();
    soft_int = 1'b0;
    csr_wr(12'h304, 32'h0);
  endtask

  task automatic test_reset_in_req();
    logic [31:0] d;
    exc_valid = 1'b1; exc_code = 5'd1; exc_pc = 32'h6000_0000; exc_tval = 32'h0;
    tick();
    exc_valid = 1'b0;
    $display("txn reset_in_req");
    n_vec++; if (trap_req !== 1'b1) begin n_err++; $display("FAIL rr_req: got %0b want 1", trap_req); end
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    n_vec++; if (trap_req !== 1'b0) begin n_err++; $display("FAIL rr_req_cleared: got %0b want 0", trap_req); end
    csr_rd(12'h305, d);
    n_vec++; if (d !== 32'h100) begin n_err++; $display("FAIL rr_mtvec: got %h want 00000100", d); end
    csr_rd(12'h300, d);
    n_vec++; if (d !== 32'h1800) begin n_err++; $display("FAIL rr_mstatus: got %h want 00001800", d); end
  endtask

  initial begin
    cpu_rst = 1'b1;
    kplic_int = 1'b0; timer_int = 1'b0; soft_int = 1'b0; lirq = 4'b0;
    exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'h0; exc_tval = 32'h0;
    int_pc = 32'h0; irq_ok = 1'b0; mret = 1'b0; trap_ack = 1'b0;
    csr_wr_en = 1'b0; csr_addr = 12'h0; csr_wr_data = 32'h0;
    test_reset();
    test_mei_vectored();
    test_exc_priority();
    test_edge_lirq();
    test_hold_ack();
    test_mret_exc();
    test_csr_misc();
    test_reset_in_req();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
